// File: rtl/interrupt_ctrl_pkg.sv
// Shared definitions for the trap/interrupt sequencer: CSR addresses,
// trap cause codes, mstatus bit positions and the sequencer state encoding.
package interrupt_ctrl_pkg;

  // Machine-mode CSR addresses touched by the sequencer
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mcause values; bit 31 marks an asynchronous interrupt
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] CAUSE_BREAK   = 32'd3;
  localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_W_MEPC    = 3'd1,
    ST_W_MCAUSE  = 3'd2,
    ST_W_MSTATUS = 3'd3,
    ST_W_MRET    = 3'd4,
    ST_ASSERT    = 3'd5
  } state_t;

endpackage

// File: rtl/interrupt_ctrl_if.sv
// Bundle between the execute stage / CSR file and the trap sequencer.
// The sequencer is the slave: it consumes pipeline/CSR state and produces
// the stall, CSR write port and redirect.
interface interrupt_ctrl_if #(
  parameter int XLEN = 32
);
  logic            inst_ecall_i;
  logic            inst_ebreak_i;
  logic            inst_mret_i;
  logic [XLEN-1:0] inst_addr_i;
  logic            jump_flag_i;
  logic [XLEN-1:0] jump_addr_i;
  logic [1:0]      int_flag_i;
  logic            global_int_en_i;
  logic [XLEN-1:0] csr_mtvec_i;
  logic [XLEN-1:0] csr_mepc_i;
  logic [XLEN-1:0] csr_mstatus_i;
  logic            hold_flag_o;
  logic            we_o;
  logic [XLEN-1:0] waddr_o;
  logic [XLEN-1:0] data_o;
  logic            int_assert_o;
  logic [XLEN-1:0] int_addr_o;

  modport slave (
    input  inst_ecall_i, inst_ebreak_i, inst_mret_i, inst_addr_i,
    input  jump_flag_i, jump_addr_i, int_flag_i, global_int_en_i,
    input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    output hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o
  );

  modport master (
    output inst_ecall_i, inst_ebreak_i, inst_mret_i, inst_addr_i,
    output jump_flag_i, jump_addr_i, int_flag_i, global_int_en_i,
    output csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    input  hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o
  );

endinterface

// File: rtl/interrupt_ctrl.sv
// Trap and interrupt sequencer. On ecall/ebreak/async interrupt it stalls the
// pipeline, writes mepc, mcause and mstatus one per cycle, then strobes a
// redirect to the trap vector. On mret it restores mstatus and redirects to
// mepc. CSR-port and redirect outputs are decoded from the state register;
// only the stall request looks at the live event inputs.
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
#(
  parameter int VECTORED = 0,
  parameter int XLEN     = 32
) (
  input  logic           clk,
  input  logic           rst,
  interrupt_ctrl_if.slave bus
);

  localparam bit USE_VECTOR = (VECTORED != 0);

  state_t          state, state_next;
  logic [XLEN-1:0] cause, cause_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            is_mret, is_mret_next;

  logic            hold;
  logic            csr_we;
  logic [XLEN-1:0] csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_addr;

  logic            take_ext;
  logic            take_tmr;
  logic [XLEN-1:0] async_pc;
  logic [XLEN-1:0] vector_addr;

  // Trap entry: save MIE into MPIE, disable interrupts, record M-mode as previous
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE, stay in M-mode
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  assign take_ext = bus.global_int_en_i & bus.int_flag_i[1];
  assign take_tmr = bus.global_int_en_i & bus.int_flag_i[0];
  // An interrupt preempts the instruction in ex: resume at the branch target if ex is redirecting
  assign async_pc = bus.jump_flag_i ? bus.jump_addr_i : bus.inst_addr_i;

  // Trap vector: direct base, or base + 4*code for interrupts in vectored mode
  always_comb begin
    vector_addr = {bus.csr_mtvec_i[XLEN-1:2], 2'b00};
    if (USE_VECTOR && (bus.csr_mtvec_i[1:0] == 2'b01) && cause[31]) begin
      vector_addr = {bus.csr_mtvec_i[XLEN-1:2], 2'b00} + XLEN'({cause[4:0], 2'b00});
    end else begin
      vector_addr = {bus.csr_mtvec_i[XLEN-1:2], 2'b00};
    end
  end

  // State, latched cause/PC and return flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cause   <= '0;
      pc      <= '0;
      is_mret <= 1'b0;
    end else begin
      state   <= state_next;
      cause   <= cause_next;
      pc      <= pc_next;
      is_mret <= is_mret_next;
    end
  end

  // Event detection, next state and per-state CSR/redirect outputs
  always_comb begin
    state_next    = state;
    cause_next    = cause;
    pc_next       = pc;
    is_mret_next  = is_mret;
    hold          = 1'b0;
    csr_we        = 1'b0;
    csr_waddr     = '0;
    csr_wdata     = '0;
    redirect      = 1'b0;
    redirect_addr = '0;
    case (state)
      ST_IDLE: begin
        if (bus.inst_ecall_i) begin
          hold         = 1'b1;
          cause_next   = XLEN'(CAUSE_ECALL_M);
          pc_next      = bus.inst_addr_i;
          is_mret_next = 1'b0;
          state_next   = ST_W_MEPC;
        end else if (bus.inst_ebreak_i) begin
          hold         = 1'b1;
          cause_next   = XLEN'(CAUSE_BREAK);
          pc_next      = bus.inst_addr_i;
          is_mret_next = 1'b0;
          state_next   = ST_W_MEPC;
        end else if (bus.inst_mret_i) begin
          hold         = 1'b1;
          is_mret_next = 1'b1;
          state_next   = ST_W_MRET;
        end else if (take_ext) begin
          hold         = 1'b1;
          cause_next   = XLEN'(CAUSE_MEI);
          pc_next      = async_pc;
          is_mret_next = 1'b0;
          state_next   = ST_W_MEPC;
        end else if (take_tmr) begin
          hold         = 1'b1;
          cause_next   = XLEN'(CAUSE_MTI);
          pc_next      = async_pc;
          is_mret_next = 1'b0;
          state_next   = ST_W_MEPC;
        end else begin
          state_next   = ST_IDLE;
        end
      end
      ST_W_MEPC: begin
        hold       = 1'b1;
        csr_we     = 1'b1;
        csr_waddr  = XLEN'(CSR_MEPC);
        csr_wdata  = pc;
        state_next = ST_W_MCAUSE;
      end
      ST_W_MCAUSE: begin
        hold       = 1'b1;
        csr_we     = 1'b1;
        csr_waddr  = XLEN'(CSR_MCAUSE);
        csr_wdata  = cause;
        state_next = ST_W_MSTATUS;
      end
      ST_W_MSTATUS: begin
        hold       = 1'b1;
        csr_we     = 1'b1;
        csr_waddr  = XLEN'(CSR_MSTATUS);
        csr_wdata  = trap_mstatus(bus.csr_mstatus_i);
        state_next = ST_ASSERT;
      end
      ST_W_MRET: begin
        hold       = 1'b1;
        csr_we     = 1'b1;
        csr_waddr  = XLEN'(CSR_MSTATUS);
        csr_wdata  = mret_mstatus(bus.csr_mstatus_i);
        state_next = ST_ASSERT;
      end
      ST_ASSERT: begin
        hold          = 1'b1;
        redirect      = 1'b1;
        redirect_addr = is_mret ? bus.csr_mepc_i : vector_addr;
        state_next    = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.hold_flag_o  = hold;
  assign bus.we_o         = csr_we;
  assign bus.waddr_o      = csr_waddr;
  assign bus.data_o       = csr_wdata;
  assign bus.int_assert_o = redirect;
  assign bus.int_addr_o   = redirect_addr;

endmodule
